// File: rtl/spi_slave_core_pkg.sv
// Shared definitions for the SPI slave: mode encodings, idle transmit fill and FSM state type.
package spi_slave_core_pkg;

  // Mode encodings as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Every bit of the default fill word takes this value.
  localparam bit TX_FILL_BIT = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_slave_core_edge_sync.sv
// Multi-flop synchroniser with one extra delay flop, giving a clean level plus
// single-cycle rise and fall pulses in the clk domain.
module spi_slave_core_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave: configurable width, mode and bit order, buffered tx holding register,
// cs_n framing with underrun and partial-word abort reporting. Entirely in the clk domain.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter bit                CPOL        = 1'b1,
  parameter bit                CPHA        = 1'b1,
  parameter bit                LSB_FIRST   = 1'b0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_FILL     = {DATA_W{TX_FILL_BIT}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cs_n_i,
  input  logic              sck_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              frame_abort_o,
  output logic              busy_o,
  output state_e            state_o
);

  localparam int             CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

  // Handshake: a tx word is taken on any clk edge where tx_valid_i && tx_ready_o;
  // tx_ready_o is low exactly while the holding register is full. rx has no backpressure.

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_slave_core_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sck_sync (
    .clk(clk), .rstn(rstn), .d_i(sck_i),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_slave_core_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rstn(rstn), .d_i(cs_n_i),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall_unused)
  );

  spi_slave_core_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rstn(rstn), .d_i(mosi_i),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              miso_q, miso_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  logic lead_e, trail_e, sample_e, shift_e, word_done, cs_end, word_start;

  always_comb begin
    lead_e     = CPOL ? sck_fall : sck_rise;
    trail_e    = CPOL ? sck_rise : sck_fall;
    // Edges count while the registered state is ACTIVE, so a last sample edge
    // arriving together with the cs_n rise still completes its word.
    sample_e   = (state_q == ACTIVE) && (CPHA ? trail_e : lead_e);
    shift_e    = (state_q == ACTIVE) && (CPHA ? lead_e : trail_e);
    word_done  = sample_e && (cnt_q == LAST);
    cs_end     = (state_q == ACTIVE) && cs_rise;
    word_start = ((state_q == IDLE) && !cs_lvl) || (word_done && !cs_end);
  end

  always_comb begin
    logic [DATA_W-1:0] word;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    miso_d      = miso_q;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    word        = TX_FILL;

    unique case (state_q)
      IDLE:    if (!cs_lvl) state_d = ACTIVE;
      ACTIVE:  if (cs_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE) && !cs_lvl) cnt_d = '0;

    if (sample_e) begin
      rx_sh_d = LSB_FIRST ? {mosi_lvl, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], mosi_lvl};
      if (cnt_q == LAST) begin
        cnt_d      = '0;
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // With CPHA=0 the trailing edge that follows a word's last sample belongs to
    // the new word, whose first bit is already on miso.
    if (shift_e && (CPHA || (cnt_q != '0))) begin
      miso_d  = first_bit(tx_sh_q);
      tx_sh_d = shift_out(tx_sh_q);
    end

    if (word_start) begin
      if (hold_full_q) begin
        word        = hold_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d  = 1'b1;
      end
      if (!CPHA) begin
        miso_d  = first_bit(word);
        tx_sh_d = shift_out(word);
      end else begin
        tx_sh_d = word;
      end
    end

    if (cs_end) begin
      if (!word_done && ((cnt_q != '0) || sample_e)) abort_d = 1'b1;
      cnt_d   = '0;
      tx_sh_d = '0;
      miso_d  = 1'b0;
    end

    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_sh_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      miso_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      miso_q      <= miso_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = (state_q == ACTIVE);
  assign busy_o        = (state_q == ACTIVE);
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_abort_o = abort_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: three instances (mode 3 8-bit MSB, mode 0 and mode 1
// 16-bit LSB) driven by a bit-level SPI master model.
module tb_spi_slave_core;
  import spi_slave_core_pkg::*;

  localparam int H = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- pins ----------------
  logic [2:0]  cs_n = 3'b111;
  logic [2:0]  sck = 3'b001;
  logic [2:0]  mosi = 3'b000;
  logic [2:0]  tx_valid = 3'b000;
  logic [15:0] tx_data [3];
  logic [2:0]  miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
  logic [7:0]  rx_d0;
  logic [15:0] rx_d1, rx_d2;
  state_e      st [3];

  int cfg_w [3]    = '{8, 16, 16};
  bit cfg_cpol [3] = '{1'b1, 1'b0, 1'b0};
  bit cfg_cpha [3] = '{1'b1, 1'b0, 1'b1};
  bit cfg_lsb [3]  = '{1'b0, 1'b1, 1'b1};

  spi_slave_core u_m3 (
    .clk(clk), .rstn(rstn), .cs_n_i(cs_n[0]), .sck_i(sck[0]), .mosi_i(mosi[0]),
    .miso_o(miso[0]), .miso_oe_o(miso_oe[0]), .tx_data_i(tx_data[0][7:0]),
    .tx_valid_i(tx_valid[0]), .tx_ready_o(tx_ready[0]), .rx_data_o(rx_d0),
    .rx_valid_o(rx_valid[0]), .tx_underrun_o(tx_underrun[0]),
    .frame_abort_o(frame_abort[0]), .busy_o(busy[0]), .state_o(st[0])
  );

  spi_slave_core #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .rstn(rstn), .cs_n_i(cs_n[1]), .sck_i(sck[1]), .mosi_i(mosi[1]),
    .miso_o(miso[1]), .miso_oe_o(miso_oe[1]), .tx_data_i(tx_data[1]),
    .tx_valid_i(tx_valid[1]), .tx_ready_o(tx_ready[1]), .rx_data_o(rx_d1),
    .rx_valid_o(rx_valid[1]), .tx_underrun_o(tx_underrun[1]),
    .frame_abort_o(frame_abort[1]), .busy_o(busy[1]), .state_o(st[1])
  );

  spi_slave_core #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_m1 (
    .clk(clk), .rstn(rstn), .cs_n_i(cs_n[2]), .sck_i(sck[2]), .mosi_i(mosi[2]),
    .miso_o(miso[2]), .miso_oe_o(miso_oe[2]), .tx_data_i(tx_data[2]),
    .tx_valid_i(tx_valid[2]), .tx_ready_o(tx_ready[2]), .rx_data_o(rx_d2),
    .rx_valid_o(rx_valid[2]), .tx_underrun_o(tx_underrun[2]),
    .frame_abort_o(frame_abort[2]), .busy_o(busy[2]), .state_o(st[2])
  );

  function automatic logic [15:0] rxd(input int k);
    case (k)
      0:       return {8'h00, rx_d0};
      1:       return rx_d1;
      default: return rx_d2;
    endcase
  endfunction

  // ---------------- pulse monitor ----------------
  logic [15:0] rx_log [3][64];
  int rx_cnt [3] = '{0, 0, 0};
  int uf_cnt [3] = '{0, 0, 0};
  int ab_cnt [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rx_valid[k]) begin
        rx_log[k][rx_cnt[k] % 64] = rxd(k);
        rx_cnt[k]++;
      end
      if (tx_underrun[k]) uf_cnt[k]++;
      if (frame_abort[k]) ab_cnt[k]++;
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic check_rx(input int k, input int base, input string name);
    int n;
    logic [15:0] e;
    n = exp_q.size();
    chk_i({name, "_nvalid"}, rx_cnt[k] - base, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (base + i < rx_cnt[k]) chk({name, "_rx"}, rx_log[k][(base + i) % 64], e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input int k, input logic [15:0] v);
    tx_data[k]  = v;
    tx_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    tx_valid[k] = 1'b0;
  endtask

  task automatic cs_begin(input int k);
    cs_n[k] = 1'b0;
  endtask

  task automatic cs_end(input int k);
    wait_clk(H);
    cs_n[k] = 1'b1;
    wait_clk(2 * H);
  endtask

  // Master shifts n bits of dout and collects miso into din at the bit's own index.
  task automatic frame_bits(input int k, input int n, input logic [15:0] dout,
                            output logic [15:0] din);
    int b;
    din = '0;
    for (int i = 0; i < n; i++) begin
      b = cfg_lsb[k] ? i : cfg_w[k] - 1 - i;
      if (!cfg_cpha[k]) begin
        mosi[k] = dout[b];
        wait_clk(H);
        din[b] = miso[k];
        sck[k] = ~cfg_cpol[k];
        wait_clk(H);
        sck[k] = cfg_cpol[k];
      end else begin
        wait_clk(H);
        sck[k] = ~cfg_cpol[k];
        mosi[k] = dout[b];
        wait_clk(H);
        din[b] = miso[k];
        sck[k] = cfg_cpol[k];
      end
    end
  endtask

  typedef struct {
    int          k;
    logic [15:0] tx;
    logic [15:0] mo;
    logic [15:0] rx_exp;
    logic [15:0] mi_exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] din;
    int rb, ub, ab;

    vecs[0] = '{0, 16'h00A5, 16'h003C, 16'h003C, 16'h00A5};
    vecs[1] = '{1, 16'hBEEF, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[2] = '{2, 16'hBEEF, 16'h1234, 16'h1234, 16'hBEEF};
    vecs[3] = '{0, 16'h0000, 16'h00FF, 16'h00FF, 16'h0000};
    vecs[4] = '{1, 16'h8001, 16'h00F0, 16'h00F0, 16'h8001};
    vecs[5] = '{2, 16'h0F0F, 16'hA55A, 16'hA55A, 16'h0F0F};
    for (int k = 0; k < 3; k++) tx_data[k] = '0;

    // reset state
    wait_clk(3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_miso%0d", k), 16'(miso[k]), 16'h0);
      chk($sformatf("rst_oe%0d", k), 16'(miso_oe[k]), 16'h0);
      chk($sformatf("rst_busy%0d", k), 16'(busy[k]), 16'h0);
      chk($sformatf("rst_txrdy%0d", k), 16'(tx_ready[k]), 16'h1);
      chk($sformatf("rst_rxdata%0d", k), rxd(k), 16'h0);
    end
    rstn = 1'b1;
    wait_clk(5);

    // single-word frames from the table
    for (int v = 0; v < 6; v++) begin
      int k;
      k = vecs[v].k;
      push_tx(k, vecs[v].tx);
      chk($sformatf("v%0d_txrdy_full", v), 16'(tx_ready[k]), 16'h0);
      rb = rx_cnt[k];
      exp_q.push_back(vecs[v].rx_exp);
      cs_begin(k);
      frame_bits(k, cfg_w[k], vecs[v].mo, din);
      chk($sformatf("v%0d_busy", v), 16'(busy[k]), 16'h1);
      chk($sformatf("v%0d_oe", v), 16'(miso_oe[k]), 16'h1);
      chk($sformatf("v%0d_state", v), 16'(st[k]), 16'(ACTIVE));
      cs_end(k);
      chk($sformatf("v%0d_miso", v), din, vecs[v].mi_exp);
      check_rx(k, rb, $sformatf("v%0d", v));
      chk($sformatf("v%0d_txrdy", v), 16'(tx_ready[k]), 16'h1);
      chk($sformatf("v%0d_idle", v), 16'(busy[k]), 16'h0);
    end

    // three-word burst, tx loaded only for word 1
    rb = rx_cnt[0];
    ub = uf_cnt[0];
    push_tx(0, 16'h0081);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0033);
    cs_begin(0);
    frame_bits(0, 8, 16'h0011, din);
    chk("burst_w1_miso", din, 16'h0081);
    frame_bits(0, 8, 16'h0022, din);
    chk("burst_w2_miso", din, 16'h00FF);
    wait_clk(6);
    chk_i("burst_underruns", uf_cnt[0] - ub, 2);
    frame_bits(0, 8, 16'h0033, din);
    chk("burst_w3_miso", din, 16'h00FF);
    cs_end(0);
    check_rx(0, rb, "burst");

    // tx write coinciding with a word start, then a write while full
    rb = rx_cnt[0];
    ub = uf_cnt[0];
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    cs_begin(0);
    wait_clk(2);
    push_tx(0, 16'h006B);
    chk("coin_txrdy", 16'(tx_ready[0]), 16'h0);
    push_tx(0, 16'h0099);
    chk("full_txrdy", 16'(tx_ready[0]), 16'h0);
    frame_bits(0, 8, 16'h0001, din);
    chk("coin_w1_miso", din, 16'h00FF);
    wait_clk(6);
    chk_i("coin_underruns", uf_cnt[0] - ub, 1);
    frame_bits(0, 8, 16'h0002, din);
    chk("coin_w2_miso", din, 16'h006B);
    cs_end(0);
    check_rx(0, rb, "coin");
    chk("coin_txrdy_end", 16'(tx_ready[0]), 16'h1);

    // cs_n raised after 5 bits
    rb = rx_cnt[0];
    ab = ab_cnt[0];
    cs_begin(0);
    frame_bits(0, 5, 16'h00FF, din);
    cs_end(0);
    chk_i("abort_pulses", ab_cnt[0] - ab, 1);
    chk_i("abort_no_rx", rx_cnt[0] - rb, 0);
    chk("abort_rxdata", rxd(0), 16'h0002);
    rb = rx_cnt[0];
    exp_q.push_back(16'h00C3);
    cs_begin(0);
    frame_bits(0, 8, 16'h00C3, din);
    cs_end(0);
    check_rx(0, rb, "after_abort");
    chk_i("after_abort_no_abort", ab_cnt[0] - ab, 1);

    // reset asserted mid-frame
    push_tx(0, 16'h003E);
    cs_begin(0);
    frame_bits(0, 4, 16'h00F0, din);
    ab = ab_cnt[0];
    rb = rx_cnt[0];
    rstn = 1'b0;
    wait_clk(1);
    chk("mid_rst_miso", 16'(miso[0]), 16'h0);
    chk("mid_rst_oe", 16'(miso_oe[0]), 16'h0);
    chk("mid_rst_busy", 16'(busy[0]), 16'h0);
    chk("mid_rst_txrdy", 16'(tx_ready[0]), 16'h1);
    chk("mid_rst_rxdata", rxd(0), 16'h0);
    chk("mid_rst_pulses", {13'h0, rx_valid[0], tx_underrun[0], frame_abort[0]}, 16'h0);
    cs_n[0] = 1'b1;
    wait_clk(4);
    rstn = 1'b1;
    wait_clk(6);
    chk_i("mid_rst_no_abort", ab_cnt[0] - ab, 0);
    chk_i("mid_rst_no_rx", rx_cnt[0] - rb, 0);
    rb = rx_cnt[0];
    exp_q.push_back(16'h005A);
    cs_begin(0);
    frame_bits(0, 8, 16'h005A, din);
    cs_end(0);
    check_rx(0, rb, "post_rst");
    chk("post_rst_miso_fill", din, 16'h00FF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
